// File: rtl/muldiv_unit_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Operation encodings, FSM states and latency helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DONE
    } state_t;

    function automatic int DIV_LAT(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first bit is produced on the start edge itself.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH-1:0] rem_cur;
    logic [WIDTH-1:0] quo_cur;
    logic [WIDTH-1:0] dvs_cur;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        rem_cur = start_i ? '0 : rem_q;
        quo_cur = start_i ? dividend_i : quo_q;
        dvs_cur = start_i ? divisor_i : dvs_q;
        part    = {rem_cur, quo_cur[WIDTH-1]};
        ge      = part >= {1'b0, dvs_cur};
        // part < 2*divisor, so the low bits hold the exact difference
        diff    = part[WIDTH-1:0] - dvs_cur;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (abort_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i || run_q) begin
            rem_q <= ge ? diff : part[WIDTH-1:0];
            quo_q <= {quo_cur[WIDTH-2:0], ge};
            if (start_i) begin
                dvs_q <= divisor_i;
                cnt_q <= CW'(WIDTH - 1);
                run_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    run_q <= 1'b0;
                end
            end
        end
    end

    assign done_o = run_q && (cnt_q == CW'(1));
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with start/done handshake.
// Results land in HI/LO registers on entry to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int MCW = $clog2(MUL_LAT) + 1;

    state_t           state_q;
    state_t           state_d;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [MCW-1:0]   mcnt_q;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    logic               in_idle;
    logic               mul_sgn;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    logic             is_sdiv;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && start_i && !flush_i;

    // Live inputs feed the multiplier only when MUL_LAT is 1
    always_comb begin
        mul_a   = in_idle ? a_i : a_q;
        mul_b   = in_idle ? b_i : b_q;
        mul_sgn = in_idle ? (op_i == OP_MULT) : (op_q == OP_MULT);
        ext_a   = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
        ext_b   = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
        prod    = ext_a * ext_b;
    end

    always_comb begin
        is_sdiv = (op_q == OP_DIV);
        abs_a   = (is_sdiv && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b   = (is_sdiv && b_q[WIDTH-1]) ? -b_q : b_q;
        fix_q   = (is_sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_q : div_q;
        fix_r   = (is_sdiv && a_q[WIDTH-1]) ? -div_r : div_r;
    end

    assign div_start = (state_q == DIV_PREP) && !flush_i;

    div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .abort_i    (flush_i),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .done_o     (div_done),
        .quo_o      (div_q),
        .rem_o      (div_r)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_i[1]) begin
                        if (b_i == '0) begin
                            state_d = DONE;
                            load    = 1'b1;
                            hi_d    = a_i;
                            lo_d    = '1;
                        end else begin
                            state_d = DIV_PREP;
                        end
                    end else if (MUL_LAT == 1) begin
                        state_d = DONE;
                        load    = 1'b1;
                        hi_d    = prod[2*WIDTH-1:WIDTH];
                        lo_d    = prod[WIDTH-1:0];
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (mcnt_q == MCW'(1)) begin
                    state_d = DONE;
                    load    = 1'b1;
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                end
            end
            DIV_PREP: state_d = DIV_ITER;
            DIV_ITER: begin
                if (div_done) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_d = DONE;
                load    = 1'b1;
                hi_d    = fix_r;
                lo_d    = fix_q;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_t'(op_i);
                a_q    <= a_i;
                b_q    <= b_i;
                mcnt_q <= MCW'(MUL_LAT - 1);
            end else if (flush_i) begin
                mcnt_q <= '0;
            end else if (state_q == MUL) begin
                mcnt_q <= mcnt_q - 1'b1;
            end
            if (load) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end
    end

    assign busy_o  = (state_q == MUL) || (state_q == DIV_PREP) ||
                     (state_q == DIV_ITER) || (state_q == DIV_FIX);
    assign done_o  = (state_q == DONE);
    assign stall_o = start_i & ~done_o & ~flush_i;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32, MUL_LAT=4.
// Expected results are hand-computed constants.
module tb_muldiv_unit;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic        flush_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_chk;
    int n_fail;

    muldiv_unit #(
        .WIDTH   (32),
        .MUL_LAT (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .flush_i (flush_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .stall_o (stall_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Starts in an IDLE cycle (cycle 0), returns in the done cycle.
    // start_i is left high so DONE must ignore it.
    task automatic run_op(input string tag,
                          input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int lat,
                          input logic [31:0] eh,
                          input logic [31:0] el);
        int c;
        int n_stall;
        int n_busy;
        c       = 0;
        n_stall = 0;
        n_busy  = 0;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1;
        if (stall_o) n_stall++;
        if (busy_o) n_busy++;
        while (!done_o && c < 200) begin
            tick();
            c++;
            if (stall_o) n_stall++;
            if (busy_o) n_busy++;
        end
        check({tag, " latency"}, 64'(c), 64'(lat));
        check({tag, " hi"}, {32'h0, hi_o}, {32'h0, eh});
        check({tag, " lo"}, {32'h0, lo_o}, {32'h0, el});
        check({tag, " stall cycles"}, 64'(n_stall), 64'(lat));
        check({tag, " busy cycles"}, 64'(n_busy), 64'(lat - 1));
    endtask

    task automatic idle_gap(input string tag);
        start_i = 1'b0;
        tick();
        check({tag, " done pulse"}, {63'h0, done_o}, 64'h0);
        check({tag, " busy idle"}, {63'h0, busy_o}, 64'h0);
    endtask

    initial begin
        int n_done;
        n_chk   = 0;
        n_fail  = 0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        flush_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        check("rst busy", {63'h0, busy_o}, 64'h0);
        check("rst done", {63'h0, done_o}, 64'h0);
        check("rst hi", {32'h0, hi_o}, 64'h0);
        check("rst lo", {32'h0, lo_o}, 64'h0);

        run_op("mult neg", 2'b00, 32'hFFFFFFFD, 32'h00000007,
               4, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check("mult stall at done", {63'h0, stall_o}, 64'h0);
        idle_gap("mult neg");

        run_op("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
               4, 32'hFFFFFFFE, 32'h00000001);
        tick();
        run_op("multu b2b", 2'b01, 32'h00010000, 32'h00010000,
               4, 32'h00000001, 32'h00000000);
        idle_gap("multu b2b");

        run_op("div neg", 2'b10, 32'hFFFFFFF9, 32'h00000002,
               34, 32'hFFFFFFFF, 32'hFFFFFFFD);
        idle_gap("div neg");
        run_op("div min", 2'b10, 32'h80000000, 32'hFFFFFFFF,
               34, 32'h00000000, 32'h80000000);
        idle_gap("div min");
        run_op("div negb", 2'b10, 32'h00000007, 32'hFFFFFFFE,
               34, 32'h00000001, 32'hFFFFFFFD);
        idle_gap("div negb");
        run_op("divu", 2'b11, 32'h00000064, 32'h00000007,
               34, 32'h00000002, 32'h0000000E);
        idle_gap("divu");
        run_op("divu zero", 2'b11, 32'h00000064, 32'h00000000,
               1, 32'h00000064, 32'hFFFFFFFF);
        idle_gap("divu zero");
        run_op("div zero", 2'b10, 32'h80000000, 32'h00000000,
               1, 32'h80000000, 32'hFFFFFFFF);
        idle_gap("div zero");

        run_op("mult small", 2'b00, 32'h00000002, 32'h00000003,
               4, 32'h00000000, 32'h00000006);
        idle_gap("mult small");

        start_i = 1'b1;
        op_i    = 2'b11;
        a_i     = 32'h00000064;
        b_i     = 32'h00000007;
        n_done  = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (done_o) n_done++;
        end
        check("flush busy before", {63'h0, busy_o}, 64'h1);
        flush_i = 1'b1;
        #1;
        check("flush stall", {63'h0, stall_o}, 64'h0);
        tick();
        flush_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("flush busy after", {63'h0, busy_o}, 64'h0);
        check("flush hi", {32'h0, hi_o}, 64'h0);
        check("flush lo", {32'h0, lo_o}, 64'h6);
        for (int c = 0; c < 30; c++) begin
            if (done_o) n_done++;
            tick();
        end
        check("flush no done", 64'(n_done), 64'h0);
        check("flush lo hold", {32'h0, lo_o}, 64'h6);

        start_i = 1'b1;
        op_i    = 2'b00;
        a_i     = 32'h00000005;
        b_i     = 32'h00000006;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        check("mid rst busy", {63'h0, busy_o}, 64'h0);
        check("mid rst done", {63'h0, done_o}, 64'h0);
        check("mid rst stall", {63'h0, stall_o}, 64'h0);
        check("mid rst hi", {32'h0, hi_o}, 64'h0);
        check("mid rst lo", {32'h0, lo_o}, 64'h0);
        run_op("mult after rst", 2'b00, 32'h00000005, 32'h00000006,
               4, 32'h00000000, 32'h0000001E);
        idle_gap("mult after rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
